// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: circular capture of per-stage valid/PC with post-trigger stop and oldest-first readout.
// Optional timestamp field per entry when TRACE_TIMESTAMP_EN is defined.
module pipe_trace_buffer #(
  parameter int STAGES    = 5,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 16,
  localparam int AW       = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_ON    = 1,
`else
  localparam int TS_ON    = 0,
`endif
  localparam int ENTRY_W  = STAGES * (PC_W + 1) + TS_ON * TS_W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [STAGES-1:0]      stageValid,
  input  logic [STAGES*PC_W-1:0] stagePC,
  input  logic                   arm,
  input  logic                   trigExt,
  input  logic [PC_W-1:0]        trigPC,
  input  logic                   trigPCEn,
  input  logic                   rdReq,
  output logic                   rdValid,
  output logic [ENTRY_W-1:0]     rdData,
  output logic                   rdLast,
  output logic [1:0]             state,
  output logic [AW:0]            entryCount
);

  localparam int CW = AW + 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [1:0]         state_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      rd_left_r;
  logic [AW-1:0]      post_cnt_r;
  logic               rd_valid_r;
  logic               rd_last_r;
  logic [ENTRY_W-1:0] rd_data_r;

  logic               trig_s;
  logic               wr_en_s;
  logic [AW-1:0]      wr_ptr_inc_s;
  logic [CW-1:0]      count_inc_s;
  logic [AW-1:0]      rd_start_s;
  logic [ENTRY_W-1:0] snapshot_s;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running cycle counter; never stops across states.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  assign snapshot_s = {ts_r, stageValid, stagePC};
`else
  assign snapshot_s = {stageValid, stagePC};
`endif

  // Trigger detect and next-pointer arithmetic shared by capture and readout setup.
  always_comb begin
    trig_s       = trigExt | (trigPCEn & stageValid[0] & (stagePC[PC_W-1:0] == trigPC));
    wr_en_s      = (state_r == ST_ARMED) || (state_r == ST_POST);
    wr_ptr_inc_s = wr_ptr_r + AW'(1);
    count_inc_s  = (count_r == CW'(DEPTH)) ? count_r : count_r + CW'(1);
    // After a wrap the oldest entry sits at the write pointer, which this also yields.
    rd_start_s   = wr_ptr_inc_s - count_inc_s[AW-1:0];
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge Clk) begin
    if (wr_en_s && !Reset && !arm) begin
      mem_r[wr_ptr_r] <= snapshot_s;
    end
  end

  // Control: arm has priority, then capture or readout depending on state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      rd_left_r  <= {CW{1'b0}};
      post_cnt_r <= {AW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {ENTRY_W{1'b0}};
    end else if (arm) begin
      state_r    <= ST_ARMED;
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      post_cnt_r <= AW'(POST_TRIG);
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      case (state_r)
        ST_ARMED: begin
          wr_ptr_r <= wr_ptr_inc_s;
          count_r  <= count_inc_s;
          if (trig_s) begin
            if (POST_TRIG == 0) begin
              state_r   <= ST_DONE;
              rd_ptr_r  <= rd_start_s;
              rd_left_r <= count_inc_s;
            end else begin
              state_r <= ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_ptr_r <= wr_ptr_inc_s;
          count_r  <= count_inc_s;
          if (post_cnt_r == AW'(1)) begin
            state_r   <= ST_DONE;
            rd_ptr_r  <= rd_start_s;
            rd_left_r <= count_inc_s;
          end else begin
            post_cnt_r <= post_cnt_r - AW'(1);
          end
        end
        ST_DONE: begin
          if (rdReq && (rd_left_r != {CW{1'b0}})) begin
            rd_valid_r <= 1'b1;
            rd_last_r  <= (rd_left_r == CW'(1));
            rd_data_r  <= mem_r[rd_ptr_r];
            rd_ptr_r   <= rd_ptr_r + AW'(1);
            rd_left_r  <= rd_left_r - CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdValid    = rd_valid_r;
  assign rdLast     = rd_last_r;
  assign rdData     = rd_data_r;
  assign state      = state_r;
  assign entryCount = count_r;

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable on-chip trace buffer for the pipelined processor. Each cycle it captures a snapshot of the valid bit and PC of every pipeline stage into a circular buffer. It stops capturing a programmable number of cycles after a trigger, then plays the frozen history back oldest-first over a one-cycle read handshake. It sits beside the processor as a debug peripheral and replaces per-cycle console dumps with hardware capture.

## Interface
- STAGES, 5, number of pipeline stages traced (IF, ID, EX, MEM, WB)
- PC_W, 32, PC width per stage
- DEPTH, 16, buffer entries; power of two, ≥2
- POST_TRIG, 4, entries captured after the trigger entry; 0 ≤ POST_TRIG < DEPTH
- TS_W, 16, timestamp width (used only under TRACE_TIMESTAMP_EN)
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- stageValid  in  STAGES  per-stage valid; bit 0 = IF
- stagePC  in  STAGES*PC_W  per-stage PC; stage s at [s*PC_W +: PC_W]
- arm  in  1  pulse; clear the buffer and start capturing
- trigExt  in  1  external trigger
- trigPC  in  PC_W  PC compare value
- trigPCEn  in  1  enables trigger on stageValid[0] && stagePC[0 +: PC_W]==trigPC
- rdReq  in  1  request the next entry
- rdValid  out  1  rdData valid for this cycle
- rdData  out  ENTRY_W  {timestamp (if enabled), stageValid, stagePC}; ENTRY_W = STAGES*(PC_W+1) [+TS_W]
- rdLast  out  1  with rdValid, marks the newest entry
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- entryCount  out  log2(DEPTH)+1  valid entries held

## Operation
- IDLE: no capture. Triggers and rdReq are ignored.
- arm (any state): wrPtr=0, count=0, postCnt=POST_TRIG, next state ARMED. arm takes priority over every other event in the same cycle.
- ARMED: every cycle, write the snapshot at wrPtr. wrPtr increments mod DEPTH. count increments and saturates at DEPTH, with the oldest entry overwritten.
- Trigger = trigExt || (trigPCEn && PC match), evaluated only in ARMED. The snapshot of the trigger cycle is written.
  - POST_TRIG>0: go to POST.
  - POST_TRIG=0: go to DONE.
- POST: capture continues. postCnt decrements per write. The write with postCnt==1 is the last one, then go to DONE. Triggers in POST or DONE are ignored.
- DONE: writes stop. rdPtr initialises to (wrPtr − count) mod DEPTH on DONE entry, and rdLeft=count.
- Readout: rdReq with rdLeft>0 → next cycle rdValid=1 with rdData=mem[rdPtr]. rdPtr then increments and rdLeft decrements. rdLast=1 when rdLeft was 1.
  - rdReq with rdLeft=0, or outside DONE: ignored, rdValid=0.
  - After the last read, state stays DONE and entryCount stays unchanged. Re-arming is required to capture again.
- Buffer mem is not reset. Only the pointers, counters and state are reset.

## Timing
- Reset: state=IDLE, rdValid=0, rdLast=0, rdData=0, entryCount=0, wrPtr=rdPtr=0, timestamp=0.
- Capture latency: inputs sampled at edge N are stored at edge N.
- arm at edge N: the first capture happens at edge N+1.
- Trigger sampled at edge T is entry T. With POST_TRIG=P, the final capture is at edge T+P, and state=DONE is visible after edge T+P.
- Read latency: 1 cycle. Back-to-back rdReq gives one entry per cycle.
- Reset asserted mid-capture or mid-readout: everything returns to reset values at that edge. rdValid deasserts the same edge.
- entryCount wraps never; it saturates at DEPTH.

## Configuration
- TRACE_TIMESTAMP_EN defined: a free-running TS_W-bit cycle counter runs from Reset, wraps mod 2^TS_W, and never stops across states. Each entry stores the counter value at its capture edge in the MSBs of rdData, so ENTRY_W includes TS_W.
- TRACE_TIMESTAMP_EN undefined: no counter and no timestamp field. ENTRY_W = STAGES*(PC_W+1).

## Test plan
- Reset, then rdReq for 3 cycles → state=0, rdValid=0 throughout, entryCount=0.
- arm, feed stagePC[0]=0x100,0x104,… with all valid; trigExt at the 3rd capture, POST_TRIG=4 → DONE after 7 captures. Reading 7 entries gives IF PCs 0x100…0x118, and rdLast=1 on 0x118.
- arm, run 40 cycles, then trigPCEn=1 with trigPC=0x1A0 on cycle 40 (DEPTH=16, POST_TRIG=4) → entryCount=16. The first read is the entry 11 cycles before the trigger, the newest is the trigger+4.
- POST_TRIG=0, trigExt while ARMED → DONE on the next cycle. The last read entry is the trigger snapshot.
- In POST, assert arm and trigExt together → state=ARMED, entryCount=0, and the trigger is ignored.
- With TRACE_TIMESTAMP_EN and TS_W=4, capture 20 cycles → the timestamps of consecutive entries increase by 1 and wrap 15→0.
